melody_sequencer: RTL and testbench

- Drives the melody lookup table stage: supplies `melodySelect` and `noteIndex`, consumes the returned `note_length`, and times every note in beats.
- Runs each note for `note_length` beats, then inserts a short articulation gap so that repeated notes sound distinct.
- Stops the melody on a zero-length terminator or after the last table slot, and can loop.
- Sits between the game-event logic (which issues start/stop) and the table and tone-decoder stages.

---
 rtl/melody_sequencer.sv | 154 +++++++++++++++
 tb/tb_melody_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/melody_sequencer.sv
// melody_sequencer: walks a melody table one note at a time, timing each
// note in beats, inserting a silent articulation gap between notes, and
// reporting completion. All outputs are registered from the next-state logic.
module melody_sequencer #(
  parameter int unsigned BEAT_TICKS = 6250000,
  parameter int unsigned GAP_TICKS  = 250000,
  parameter int unsigned MAX_NOTES  = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       loopEn,
  input  logic [3:0] melodyIn,
  input  logic [3:0] note_length,
  output logic [3:0] melodySelect,
  output logic [4:0] noteIndex,
  output logic       soundEn,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int unsigned PW = (BEAT_TICKS > 1) ? $clog2(BEAT_TICKS) : 1;
  localparam int unsigned GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(BEAT_TICKS - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [4:0]    IDX_LAST = 5'(MAX_NOTES - 1);

  logic [2:0]    state_q, state_d;
  logic [3:0]    sel_q, sel_d;
  logic [4:0]    idx_q, idx_d;
  logic [3:0]    beats_q, beats_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          snd_q, snd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          adv;

  // Next-state logic: per-state sequencing, then start/stop overrides.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    beats_d = beats_q;
    pre_d   = pre_q;
    gap_d   = gap_q;
    adv     = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (note_length == 4'd0) begin
          state_d = S_DONE;
        end else begin
          beats_d = note_length;
          pre_d   = '0;
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (pre_q == PRE_LAST) begin
          pre_d   = '0;
          beats_d = beats_q - 4'd1;
          if (beats_q == 4'd1) begin
            if (GAP_TICKS == 0) begin
              adv = 1'b1;
            end else begin
              gap_d   = '0;
              state_d = S_GAP;
            end
          end
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) adv = 1'b1;
        else                   gap_d = gap_q + 1'b1;
      end
      S_DONE: begin
        if (loopEn) begin
          idx_d   = '0;
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: ;
    endcase

    // Advance step is shared by the end of GAP and (with no gap) the end of PLAY.
    if (adv) begin
      if (idx_q == IDX_LAST) begin
        state_d = S_DONE;
      end else begin
        idx_d   = idx_q + 5'd1;
        state_d = S_FETCH;
      end
    end

    // stop overrides everything and must undo any index/select update above.
    if (stop) begin
      state_d = S_IDLE;
      sel_d   = sel_q;
      idx_d   = idx_q;
    end else if (start) begin
      sel_d   = melodyIn;
      idx_d   = '0;
      state_d = S_FETCH;
    end

    snd_d  = (state_d == S_PLAY);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State, counters and registered outputs with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      idx_q   <= '0;
      beats_q <= '0;
      pre_q   <= '0;
      gap_q   <= '0;
      snd_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      beats_q <= beats_d;
      pre_q   <= pre_d;
      gap_q   <= gap_d;
      snd_q   <= snd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign melodySelect = sel_q;
  assign noteIndex    = idx_q;
  assign soundEn      = snd_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer: directed scenarios with BEAT_TICKS=4, GAP_TICKS=2.
// Expected per-cycle outputs are queued from the scenario timeline and
// popped/compared every cycle at the falling clock edge.
module tb_melody_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, stop, loopEn;
  logic [3:0] melodyIn;
  logic [3:0] note_length;
  logic [3:0] melodySelect;
  logic [4:0] noteIndex;
  logic       soundEn, busy, done;

  logic [3:0] tab [16][32];

  typedef struct {
    string      tag;
    logic [11:0] v;   // {sel, idx, soundEn, busy, done}
  } exp_t;

  exp_t sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  assign note_length = tab[melodySelect][noteIndex];

  melody_sequencer #(
    .BEAT_TICKS(4),
    .GAP_TICKS (2),
    .MAX_NOTES (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .loopEn      (loopEn),
    .melodyIn    (melodyIn),
    .note_length (note_length),
    .melodySelect(melodySelect),
    .noteIndex   (noteIndex),
    .soundEn     (soundEn),
    .busy        (busy),
    .done        (done)
  );

  task automatic push(input string tag, input int unsigned n, input logic [3:0] s,
                      input logic [4:0] i, input logic sn, input logic b, input logic d);
    exp_t e;
    e.tag = tag;
    e.v   = {s, i, sn, b, d};
    repeat (n) sb.push_back(e);
  endtask

  task automatic ex_fetch(input logic [3:0] s, input logic [4:0] i);
    push("fetch", 1, s, i, 1'b0, 1'b1, 1'b0);
  endtask
  task automatic ex_play(input logic [3:0] s, input logic [4:0] i, input int unsigned cycles);
    push("play", cycles, s, i, 1'b1, 1'b1, 1'b0);
  endtask
  task automatic ex_gap(input logic [3:0] s, input logic [4:0] i, input int unsigned cycles);
    push("gap", cycles, s, i, 1'b0, 1'b1, 1'b0);
  endtask
  task automatic ex_done(input logic [3:0] s, input logic [4:0] i);
    push("done", 1, s, i, 1'b0, 1'b1, 1'b1);
  endtask
  task automatic ex_idle(input logic [3:0] s, input logic [4:0] i, input int unsigned n);
    push("idle", n, s, i, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_pop();
    exp_t e;
    logic [11:0] obs;
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL sb_empty: observed an output cycle, required a queued expectation");
      return;
    end
    e   = sb.pop_front();
    obs = {melodySelect, noteIndex, soundEn, busy, done};
    assert (obs === e.v) else begin
      n_err++;
      $error("FAIL %s @%0t: observed sel=%0d idx=%0d snd=%b busy=%b done=%b, required sel=%0d idx=%0d snd=%b busy=%b done=%b",
             e.tag, $time, obs[11:8], obs[7:3], obs[2], obs[1], obs[0],
             e.v[11:8], e.v[7:3], e.v[2], e.v[1], e.v[0]);
    end
  endtask

  // One cycle: pulse inputs drop after the edge that sampled them, then compare.
  task automatic run(input int unsigned n);
    repeat (n) begin
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      check_pop();
    end
  endtask

  initial begin
    for (int unsigned m = 0; m < 16; m++)
      for (int unsigned k = 0; k < 32; k++)
        tab[m][k] = 4'd0;
    tab[5][0] = 4'd2;
    tab[0][0] = 4'd1;
    for (int unsigned k = 0; k < 32; k++) tab[7][k] = 4'd1;

    reset = 1'b1; start = 1'b0; stop = 1'b0; loopEn = 1'b0; melodyIn = 4'd0;

    // Reset state
    ex_idle(4'd0, 5'd0, 2);
    run(2);
    reset = 1'b0;
    ex_idle(4'd0, 5'd0, 2);
    run(2);

    // Single two-beat note, melody 5
    ex_fetch(5, 0); ex_play(5, 0, 8); ex_gap(5, 0, 2); ex_fetch(5, 1);
    ex_done(5, 1); ex_idle(5, 1, 2);
    start = 1'b1; melodyIn = 4'd5;
    run(15);

    // Empty melody
    ex_fetch(3, 0); ex_done(3, 0); ex_idle(3, 0, 2);
    start = 1'b1; melodyIn = 4'd3;
    run(4);

    // All 32 slots of length 1: index stops at 31
    for (int unsigned k = 0; k < 32; k++) begin
      ex_fetch(7, 5'(k)); ex_play(7, 5'(k), 4); ex_gap(7, 5'(k), 2);
    end
    ex_done(7, 31); ex_idle(7, 31, 3);
    start = 1'b1; melodyIn = 4'd7;
    run(228);

    // Loop: second pass identical, loopEn dropped before second DONE
    ex_fetch(5, 0); ex_play(5, 0, 8); ex_gap(5, 0, 2); ex_fetch(5, 1); ex_done(5, 1);
    ex_fetch(5, 0); ex_play(5, 0, 8); ex_gap(5, 0, 2); ex_fetch(5, 1); ex_done(5, 1);
    ex_idle(5, 1, 2);
    loopEn = 1'b1; start = 1'b1; melodyIn = 4'd5;
    run(20);
    loopEn = 1'b0;
    run(8);

    // Stop during cycle 5 (mid-PLAY)
    ex_fetch(5, 0); ex_play(5, 0, 4); ex_idle(5, 0, 3);
    start = 1'b1; melodyIn = 4'd5;
    run(5);
    stop = 1'b1;
    run(3);

    // start and stop together from IDLE: stop wins
    ex_idle(5, 0, 3);
    start = 1'b1; stop = 1'b1; melodyIn = 4'd9;
    run(3);

    // start for melody 1 during the GAP of melody 0
    ex_fetch(0, 0); ex_play(0, 0, 4); ex_gap(0, 0, 1);
    ex_fetch(1, 0); ex_done(1, 0); ex_idle(1, 0, 2);
    start = 1'b1; melodyIn = 4'd0;
    run(6);
    start = 1'b1; melodyIn = 4'd1;
    run(4);

    // Asynchronous reset mid-PLAY clears outputs before the next edge
    ex_fetch(5, 0); ex_play(5, 0, 2);
    start = 1'b1; melodyIn = 4'd5;
    run(3);
    reset = 1'b1;
    #1;
    ex_idle(0, 0, 1);
    check_pop();
    ex_idle(0, 0, 1);
    run(1);
    reset = 1'b0;
    ex_idle(0, 0, 2);
    run(2);

    // Every queued expectation must have been consumed
    n_cmp++;
    assert (sb.size() === 0) else begin
      n_err++;
      $error("FAIL sb_drain: observed %0d leftover expectations, required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
